prga: RTL and testbench
=======================

PRGA -- requirements
Module: prga

Interface
REQ-001 Parameters: none; widths fixed by shared package.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 en  input  1  start request, sampled only while rdy=1.
REQ-005 rdy  output  1  high when idle and able to accept en.
REQ-006 s_addr  output  8  address into S memory, the 256-byte permuted state left by the key-scheduling stage.
REQ-007 s_rddata  input  8  S read data, valid one cycle after s_addr.
REQ-008 s_wrdata  output  8  S write data.
REQ-009 s_wren  output  1  S write enable.
REQ-010 ct_addr  output  8  ciphertext memory address.
REQ-011 ct_rddata  input  8  ciphertext read data, valid one cycle after ct_addr.
REQ-012 pt_addr  output  8  plaintext memory address.
REQ-013 pt_wrdata  output  8  plaintext write data.
REQ-014 pt_wren  output  1  plaintext write enable.

Function
REQ-015 Messages are length-prefixed: ct[0]=L (0..255); bytes ct[1..L] are the ciphertext.
REQ-016 Start: a rising edge with rdy=1 and en=1 clears i, j and k, and enters RD_LEN; en is ignored whenever rdy=0.
REQ-017 RD_LEN: ct_addr=0, no writes.
REQ-018 WR_LEN: latch L from ct_rddata; pt_addr=0, pt_wrdata=L, pt_wren=1.
REQ-019 WR_LEN exit: if L=0, go to IDLE; otherwise set k=1, i=1 and go to RD_SI.
REQ-020 Per-byte sequence is RD_SI -> RD_SJ -> WR_SI -> WR_SJ -> RD_PAD -> WR_PT, i.e. exactly 6 cycles per byte.
REQ-021 ct_addr=k throughout every per-byte state.
REQ-022 RD_SI: s_addr=i.
REQ-023 RD_SJ: latch si=s_rddata and j=(j+si) mod 256; s_addr=(j+si) mod 256.
REQ-024 WR_SI: latch sj=s_rddata; s_addr=i, s_wrdata=s_rddata, s_wren=1.
REQ-025 WR_SJ: s_addr=j, s_wrdata=si, s_wren=1.
REQ-026 RD_PAD: s_addr=(si+sj) mod 256.
REQ-027 WR_PT: pt_addr=k, pt_wrdata=s_rddata XOR ct_rddata, pt_wren=1.
REQ-028 WR_PT exit: if k=L, go to IDLE; otherwise increment k and i, then go to RD_SI.
REQ-029 All index arithmetic is 8-bit and wraps mod 256; i and j wrap silently.
REQ-030 Case i=j: sj equals si and both writes store the same value; no special handling.
REQ-031 rdy=1 only in IDLE; it reasserts in the cycle after the final write.
REQ-032 Total busy time is 2+6L cycles from the accepting edge.
REQ-033 Outside the states listed above, all write enables are 0 and all addresses and data are 0.
REQ-034 At most one of s_wren and pt_wren is high in any cycle.

Reset
REQ-035 rst=1 at any edge, including mid-message, forces IDLE and clears i, j, k, L, si and sj.
REQ-036 During and after reset: rdy=1; all wren=0; all addr and wrdata outputs=0.
REQ-037 Reset takes priority over en in the same cycle.
REQ-038 Memory contents are not restored by reset.

Structure
REQ-039 Shared package prga_pkg holds: state enum {IDLE, RD_LEN, WR_LEN, RD_SI, RD_SJ, WR_SI, WR_SJ, RD_PAD, WR_PT}, BYTE_W=8, MEM_DEPTH=256.
REQ-040 Single module with a registered FSM plus combinational output decode; no sub-module is warranted.

Verification
REQ-041 Identity S (s[n]=n), ct={3,0,0,0}, pulse en -> pt={3,02,05,07}; final S has s[2]=3, s[3]=5, s[5]=2, all else identity; rdy returns 20 cycles after start.
REQ-042 ct[0]=0 -> pt[0]=0 written once; zero S writes; rdy returns after 2 cycles.
REQ-043 Identity S, ct={3,FF,FF,FF} -> pt={3,FD,FA,F8}.
REQ-044 rst asserted in WR_SJ of byte 2 -> next cycle rdy=1 and all wren=0; a new start with S reloaded to identity gives REQ-041 results.
REQ-045 en held high throughout the busy period -> no restart; exactly one message processed, then a new start on the next rdy edge.
REQ-046 L=255 with identity S -> i wraps 255->0 with no glitch; 255 pt bytes match the reference model; 6*255+2 busy cycles.

Source files
------------

// File: rtl/prga_pkg.sv
// Shared definitions for the RC4 pseudo-random generation (decrypt) block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package prga_pkg;

    localparam int BYTE_W    = 8;
    localparam int MEM_DEPTH = 256;

    typedef enum logic [3:0] {
        IDLE,
        RD_LEN,
        WR_LEN,
        RD_SI,
        RD_SJ,
        WR_SI,
        WR_SJ,
        RD_PAD,
        WR_PT
    } state_t;

endpackage

// File: rtl/prga.sv
// RC4 keystream generator: decrypts a length-prefixed ciphertext using a pre-permuted S memory.
// Latency: 2 + 6*L cycles from the accepting edge to rdy reasserting (L = ct[0]).
// Backpressure: none; en is only accepted while rdy=1 and ignored while busy.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   en / rdy                      start request / idle indication
//   s_addr, s_rddata, s_wrdata, s_wren   S memory (sync read, 1-cycle latency)
//   ct_addr, ct_rddata            ciphertext memory (sync read, 1-cycle latency)
//   pt_addr, pt_wrdata, pt_wren   plaintext memory write port
module prga
    import prga_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic              rdy,
    output logic [BYTE_W-1:0] s_addr,
    input  logic [BYTE_W-1:0] s_rddata,
    output logic [BYTE_W-1:0] s_wrdata,
    output logic              s_wren,
    output logic [BYTE_W-1:0] ct_addr,
    input  logic [BYTE_W-1:0] ct_rddata,
    output logic [BYTE_W-1:0] pt_addr,
    output logic [BYTE_W-1:0] pt_wrdata,
    output logic              pt_wren
);

    state_t            state;
    state_t            next_state;
    logic [BYTE_W-1:0] i;
    logic [BYTE_W-1:0] j;
    logic [BYTE_W-1:0] k;
    logic [BYTE_W-1:0] len;
    logic [BYTE_W-1:0] si;
    logic [BYTE_W-1:0] sj;

    // 8-bit sums wrap mod 256 by construction.
    logic [BYTE_W-1:0] j_sum;
    logic [BYTE_W-1:0] pad_addr;
    assign j_sum    = j + s_rddata;
    assign pad_addr = si + sj;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            i     <= '0;
            j     <= '0;
            k     <= '0;
            len   <= '0;
            si    <= '0;
            sj    <= '0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (en) begin
                        i <= '0;
                        j <= '0;
                        k <= '0;
                    end
                end
                WR_LEN: begin
                    len <= ct_rddata;
                    if (ct_rddata != '0) begin
                        k <= 8'd1;
                        i <= 8'd1;
                    end
                end
                RD_SJ: begin
                    si <= s_rddata;
                    j  <= j_sum;
                end
                WR_SI: sj <= s_rddata;
                WR_PT: begin
                    if (k != len) begin
                        k <= k + 8'd1;
                        i <= i + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        next_state = state;
        rdy        = 1'b0;
        s_addr     = '0;
        s_wrdata   = '0;
        s_wren     = 1'b0;
        ct_addr    = '0;
        pt_addr    = '0;
        pt_wrdata  = '0;
        pt_wren    = 1'b0;

        case (state)
            IDLE: begin
                rdy = 1'b1;
                if (en) next_state = RD_LEN;
            end
            RD_LEN: next_state = WR_LEN;
            WR_LEN: begin
                pt_wrdata  = ct_rddata;
                pt_wren    = 1'b1;
                next_state = (ct_rddata == '0) ? IDLE : RD_SI;
            end
            RD_SI: begin
                ct_addr    = k;
                s_addr     = i;
                next_state = RD_SJ;
            end
            RD_SJ: begin
                ct_addr    = k;
                s_addr     = j_sum;
                next_state = WR_SI;
            end
            WR_SI: begin
                // s_rddata here is S[j]; it goes into slot i (first half of the swap).
                ct_addr    = k;
                s_addr     = i;
                s_wrdata   = s_rddata;
                s_wren     = 1'b1;
                next_state = WR_SJ;
            end
            WR_SJ: begin
                ct_addr    = k;
                s_addr     = j;
                s_wrdata   = si;
                s_wren     = 1'b1;
                next_state = RD_PAD;
            end
            RD_PAD: begin
                ct_addr    = k;
                s_addr     = pad_addr;
                next_state = WR_PT;
            end
            WR_PT: begin
                // ct_addr has held k since RD_SI, so ct_rddata is ct[k] by now.
                ct_addr    = k;
                pt_addr    = k;
                pt_wrdata  = s_rddata ^ ct_rddata;
                pt_wren    = 1'b1;
                next_state = (k == len) ? IDLE : RD_SI;
            end
            default: next_state = IDLE;
        endcase

        // Reset wins combinationally too, so no stray write escapes in the reset cycle.
        if (rst) begin
            next_state = IDLE;
            rdy        = 1'b1;
            s_addr     = '0;
            s_wrdata   = '0;
            s_wren     = 1'b0;
            ct_addr    = '0;
            pt_addr    = '0;
            pt_wrdata  = '0;
            pt_wren    = 1'b0;
        end
    end

endmodule

// File: tb/tb_prga.sv
module tb_prga;
    import prga_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       rdy;
    logic [7:0] s_addr, s_rddata, s_wrdata;
    logic       s_wren;
    logic [7:0] ct_addr, ct_rddata;
    logic [7:0] pt_addr, pt_wrdata;
    logic       pt_wren;

    prga dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .rdy       (rdy),
        .s_addr    (s_addr),
        .s_rddata  (s_rddata),
        .s_wrdata  (s_wrdata),
        .s_wren    (s_wren),
        .ct_addr   (ct_addr),
        .ct_rddata (ct_rddata),
        .pt_addr   (pt_addr),
        .pt_wrdata (pt_wrdata),
        .pt_wren   (pt_wren)
    );

    always #5 clk = ~clk;

    // Memory models: synchronous read, loaded from the image arrays on load_mem.
    logic [7:0] s_mem  [MEM_DEPTH];
    logic [7:0] ct_mem [MEM_DEPTH];
    logic [7:0] pt_mem [MEM_DEPTH];
    logic [7:0] s_img  [MEM_DEPTH];
    logic [7:0] ct_img [MEM_DEPTH];
    logic       load_mem = 1'b0;
    int         s_wr_cnt = 0;
    int         pt_wr_cnt = 0;
    int         dual_wr = 0;

    always @(posedge clk) begin
        s_rddata  <= s_mem[s_addr];
        ct_rddata <= ct_mem[ct_addr];
        if (s_wren && pt_wren) dual_wr <= dual_wr + 1;
        if (load_mem) begin
            for (int n = 0; n < MEM_DEPTH; n++) begin
                s_mem[n]  <= s_img[n];
                ct_mem[n] <= ct_img[n];
                pt_mem[n] <= 8'hAA;
            end
            s_wr_cnt  <= 0;
            pt_wr_cnt <= 0;
        end else begin
            if (s_wren) begin
                s_mem[s_addr] <= s_wrdata;
                s_wr_cnt      <= s_wr_cnt + 1;
            end
            if (pt_wren) begin
                pt_mem[pt_addr] <= pt_wrdata;
                pt_wr_cnt       <= pt_wr_cnt + 1;
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: textbook RC4 PRGA over plain arrays.
    logic [7:0] ref_s  [MEM_DEPTH];
    logic [7:0] ref_pt [MEM_DEPTH];
    int         ref_len;

    task automatic ref_run();
        int ii, jj;
        logic [7:0] t;
        for (int n = 0; n < MEM_DEPTH; n++) ref_s[n] = s_img[n];
        ref_len   = int'(ct_img[0]);
        ref_pt[0] = ct_img[0];
        ii = 0;
        jj = 0;
        for (int kk = 1; kk <= ref_len; kk++) begin
            ii = (ii + 1) % 256;
            jj = (jj + int'(ref_s[ii])) % 256;
            t = ref_s[ii]; ref_s[ii] = ref_s[jj]; ref_s[jj] = t;
            ref_pt[kk] = ct_img[kk] ^ ref_s[(int'(ref_s[ii]) + int'(ref_s[jj])) % 256];
        end
    endtask

    task automatic load_images();
        @(negedge clk);
        load_mem = 1'b1;
        @(posedge clk);
        #1 load_mem = 1'b0;
    endtask

    task automatic fill_identity();
        for (int n = 0; n < MEM_DEPTH; n++) s_img[n] = 8'(n);
    endtask

    task automatic fill_random_perm();
        logic [7:0] t;
        int r;
        fill_identity();
        for (int n = MEM_DEPTH - 1; n > 0; n--) begin
            r = $urandom_range(n, 0);
            t = s_img[n]; s_img[n] = s_img[r]; s_img[r] = t;
        end
    endtask

    task automatic fill_ct(input int len);
        ct_img[0] = 8'(len);
        for (int n = 1; n < MEM_DEPTH; n++) ct_img[n] = 8'($urandom);
    endtask

    // Pulses (or holds) en, returns the number of edges until rdy is seen again.
    task automatic start_and_wait(input string tag, input bit hold_en, output int cyc);
        @(negedge clk);
        en = 1'b1;
        @(posedge clk);
        #1;
        if (!hold_en) en = 1'b0;
        chk({tag, "_rdy_low"}, 32'(rdy), 32'd0);
        cyc = 0;
        while (cyc < 3000) begin
            @(posedge clk);
            cyc++;
            #1;
            if (rdy) break;
        end
    endtask

    task automatic check_msg(input string tag, input int cyc);
        int mism;
        chk({tag, "_busy"}, 32'(cyc), 32'(2 + 6 * ref_len));
        for (int n = 0; n <= ref_len; n++)
            chk($sformatf("%s_pt%0d", tag, n), 32'(pt_mem[n]), 32'(ref_pt[n]));
        mism = 0;
        for (int n = 0; n < MEM_DEPTH; n++)
            if (s_mem[n] !== ref_s[n]) mism++;
        chk({tag, "_s_mism"}, 32'(mism), 32'd0);
        chk({tag, "_pt_wr"}, 32'(pt_wr_cnt), 32'(ref_len + 1));
        chk({tag, "_s_wr"}, 32'(s_wr_cnt), 32'(2 * ref_len));
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_rdy"}, 32'(rdy), 32'd1);
        chk({tag, "_wren"}, {30'd0, s_wren, pt_wren}, 32'd0);
        chk({tag, "_addr"}, {8'd0, s_addr, ct_addr, pt_addr}, 32'd0);
        chk({tag, "_wdat"}, {16'd0, s_wrdata, pt_wrdata}, 32'd0);
    endtask

    int cyc;
    int lens [4];

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        fill_identity();
        fill_ct(0);
        load_images();
        repeat (2) @(posedge clk);
        #1 check_idle_outputs("reset_during");
        rst = 1'b0;
        @(posedge clk);
        #1 check_idle_outputs("reset_after");

        // Identity S, ct = {3,0,0,0}
        fill_identity();
        ct_img[0] = 8'd3; ct_img[1] = 8'd0; ct_img[2] = 8'd0; ct_img[3] = 8'd0;
        load_images();
        ref_run();
        start_and_wait("basic", 1'b0, cyc);
        check_msg("basic", cyc);
        chk("basic_cyc20", 32'(cyc), 32'd20);
        chk("basic_pt", {pt_mem[0], pt_mem[1], pt_mem[2], pt_mem[3]}, 32'h03020507);
        chk("basic_s235", {8'd0, s_mem[2], s_mem[3], s_mem[5]}, 32'h00030502);

        // Zero-length message
        fill_identity();
        fill_ct(0);
        load_images();
        ref_run();
        start_and_wait("len0", 1'b0, cyc);
        check_msg("len0", cyc);
        chk("len0_pt0", 32'(pt_mem[0]), 32'd0);

        // Identity S, all-ones ciphertext
        fill_identity();
        ct_img[0] = 8'd3; ct_img[1] = 8'hFF; ct_img[2] = 8'hFF; ct_img[3] = 8'hFF;
        load_images();
        ref_run();
        start_and_wait("ff", 1'b0, cyc);
        check_msg("ff", cyc);
        chk("ff_pt", {8'd0, pt_mem[1], pt_mem[2], pt_mem[3]}, 32'h00FDFAF8);

        // Reset in WR_SJ of byte 2 (11 edges after the accepting edge)
        fill_identity();
        ct_img[0] = 8'd3; ct_img[1] = 8'd0; ct_img[2] = 8'd0; ct_img[3] = 8'd0;
        load_images();
        @(negedge clk);
        en = 1'b1;
        @(posedge clk);
        #1 en = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        chk("midrst_wrsj", {23'd0, s_wren, s_addr}, {23'd0, 1'b1, 8'd3});
        rst = 1'b1;
        #1 chk("midrst_during_wren", {30'd0, s_wren, pt_wren}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        check_idle_outputs("midrst_after");
        load_images();
        ref_run();
        start_and_wait("restart", 1'b0, cyc);
        check_msg("restart", cyc);
        chk("restart_pt", {pt_mem[0], pt_mem[1], pt_mem[2], pt_mem[3]}, 32'h03020507);

        // en held high for the whole busy period
        fill_random_perm();
        fill_ct(5);
        load_images();
        ref_run();
        start_and_wait("hold", 1'b1, cyc);
        check_msg("hold", cyc);
        @(posedge clk);
        #1 chk("hold_restart_rdy", 32'(rdy), 32'd0);
        en = 1'b0;
        cyc = 0;
        while (cyc < 3000) begin
            @(posedge clk);
            cyc++;
            #1;
            if (rdy) break;
        end
        chk("hold_second_busy", 32'(cyc), 32'(2 + 6 * 5));
        chk("hold_second_pt_wr", 32'(pt_wr_cnt), 32'd12);

        // Random permutations and ciphertexts
        lens[0] = 1;
        lens[1] = $urandom_range(40, 2);
        lens[2] = $urandom_range(40, 2);
        lens[3] = $urandom_range(120, 41);
        foreach (lens[t]) begin
            fill_random_perm();
            fill_ct(lens[t]);
            load_images();
            ref_run();
            start_and_wait($sformatf("rnd%0d", t), 1'b0, cyc);
            check_msg($sformatf("rnd%0d", t), cyc);
        end

        // Maximum length: i wraps 255 -> 0
        fill_identity();
        fill_ct(255);
        load_images();
        ref_run();
        start_and_wait("max_id", 1'b0, cyc);
        check_msg("max_id", cyc);
        chk("max_id_cyc", 32'(cyc), 32'd1532);

        fill_random_perm();
        fill_ct(255);
        load_images();
        ref_run();
        start_and_wait("max_rnd", 1'b0, cyc);
        check_msg("max_rnd", cyc);

        chk("dual_wren", 32'(dual_wr), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
